// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_ctrl_pkg
// Brief    : Shared FSM state type, adder-slave register offsets and timeout.
// Revision : 1.0 - initial release
// ============================================================================
package adder_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_A = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD   = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  localparam logic [7:0] c_OFF_A   = 8'h00;
  localparam logic [7:0] c_OFF_B   = 8'h04;
  localparam logic [7:0] c_OFF_SUM = 8'h08;

  localparam int unsigned ADDER_CTRL_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/axil_wr_xfer.sv
`default_nettype none
// ============================================================================
// Module   : axil_wr_xfer
// Brief    : One AXI-Lite AW/W/B write transfer, launched by a start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module axil_wr_xfer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic                    bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic                    done_o,
  output logic                    err_o
);

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  aw_acc_q;
  logic                  w_acc_q;
  logic                  aw_acc_d;
  logic                  w_acc_d;

  // Acceptance as of the end of this cycle, so bready can rise on the
  // edge that completes the later of the two address/data handshakes.
  assign aw_acc_d = aw_acc_q | (awvalid_q & awready_i);
  assign w_acc_d  = w_acc_q  | (wvalid_q  & wready_i);

  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_acc_q  <= 1'b0;
      w_acc_q   <= 1'b0;
      if (rst) begin
        awaddr_q <= '0;
        wdata_q  <= '0;
      end
    end else if (start_i) begin
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      bready_q  <= 1'b0;
      aw_acc_q  <= 1'b0;
      w_acc_q   <= 1'b0;
      awaddr_q  <= addr_i;
      wdata_q   <= data_i;
    end else begin
      if (awvalid_q && awready_i) begin
        awvalid_q <= 1'b0;
        aw_acc_q  <= 1'b1;
      end
      if (wvalid_q && wready_i) begin
        wvalid_q <= 1'b0;
        w_acc_q  <= 1'b1;
      end
      if (bready_q && bvalid_i) begin
        bready_q <= 1'b0;
        aw_acc_q <= 1'b0;
        w_acc_q  <= 1'b0;
      end else if (aw_acc_d && w_acc_d) begin
        bready_q <= 1'b1;
      end
    end
  end

  assign awaddr_o  = awaddr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = {(DATA_WIDTH/8){1'b1}};
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign done_o    = bready_q & bvalid_i;
  assign err_o     = bresp_i;

endmodule
`default_nettype wire

// File: rtl/adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_ctrl
// Brief    : Job controller: writes A and B to an AXI-Lite adder, reads sum.
//            Optional handshake timeout enabled by ADDER_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_sum,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] rsp_sum_q;
  logic                  rsp_valid_q;
  logic                  err_q;
  logic                  cmd_ready_q;
  logic                  wr_start_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  rready_q;

  logic                  wr_start;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;
  logic                  wr_err;
  logic                  abort;

  // Operand B is launched on the same edge that retires operand A's response.
  assign wr_start = wr_start_q | ((state_q == ST_WR_A) & wr_done);
  assign wr_addr  = wr_start_q ? (BASE_ADDR + ADDR_WIDTH'(c_OFF_A))
                               : (BASE_ADDR + ADDR_WIDTH'(c_OFF_B));
  assign wr_data  = wr_start_q ? a_q : b_q;

  axil_wr_xfer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_xfer (
    .clk       (m1_axi_aclk),
    .rst       (m1_axi_areset),
    .start_i   (wr_start),
    .abort_i   (abort),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .awaddr_o  (m1_axi_awaddr),
    .awvalid_o (m1_axi_awvalid),
    .awready_i (m1_axi_awready),
    .wdata_o   (m1_axi_wdata),
    .wstrb_o   (m1_axi_wstrb),
    .wvalid_o  (m1_axi_wvalid),
    .wready_i  (m1_axi_wready),
    .bresp_i   (m1_axi_bresp),
    .bvalid_i  (m1_axi_bvalid),
    .bready_o  (m1_axi_bready),
    .done_o    (wr_done),
    .err_o     (wr_err)
  );

`ifdef ADDER_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ADDER_CTRL_TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt_q;
  logic            waiting;
  logic            progress;

  // Any handshake restarts the wait window; only AXI waits are bounded.
  assign waiting  = (state_q == ST_WR_A) || (state_q == ST_WR_B) || (state_q == ST_RD);
  assign progress = wr_start_q
                  | (m1_axi_awvalid & m1_axi_awready)
                  | (m1_axi_wvalid  & m1_axi_wready)
                  | (m1_axi_bvalid  & m1_axi_bready)
                  | (arvalid_q      & m1_axi_arready)
                  | (m1_axi_rvalid  & rready_q);
  assign abort    = waiting && !progress && (wait_cnt_q == TO_W'(ADDER_CTRL_TIMEOUT - 1));

  always_ff @(posedge m1_axi_aclk) begin
    if (m1_axi_areset || !waiting || progress || abort) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge m1_axi_aclk) begin
    if (m1_axi_areset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_start_q  <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
    end else begin
      wr_start_q <= 1'b0;
      if (abort) begin
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_sum_q   <= '0;
        err_q       <= 1'b1;
        rsp_valid_q <= 1'b1;
        state_q     <= ST_RSP;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
              a_q         <= cmd_a;
              b_q         <= cmd_b;
              err_q       <= 1'b0;
              cmd_ready_q <= 1'b0;
              wr_start_q  <= 1'b1;
              state_q     <= ST_WR_A;
            end
          end
          ST_WR_A: begin
            if (wr_done) begin
              err_q   <= err_q | wr_err;
              state_q <= ST_WR_B;
            end
          end
          ST_WR_B: begin
            if (wr_done) begin
              err_q     <= err_q | wr_err;
              arvalid_q <= 1'b1;
              araddr_q  <= BASE_ADDR + ADDR_WIDTH'(c_OFF_SUM);
              state_q   <= ST_RD;
            end
          end
          ST_RD: begin
            if (arvalid_q && m1_axi_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
            end
            if (rready_q && m1_axi_rvalid) begin
              rready_q    <= 1'b0;
              rsp_sum_q   <= m1_axi_rdata;
              err_q       <= err_q | m1_axi_rresp;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RSP;
            end
          end
          ST_RSP: begin
            if (rsp_ready) begin
              rsp_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_sum        = rsp_sum_q;
  assign rsp_err        = err_q;
  assign m1_axi_arvalid = arvalid_q;
  assign m1_axi_araddr  = araddr_q;
  assign m1_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_ctrl
// Brief    : Directed self-checking bench for adder_ctrl with an adder slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_sum;
  logic        rsp_err;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration, set by the directed sequence.
  int   aw_delay  = 0;
  logic err_on_b  = 1'b0;
  logic ar_en     = 1'b1;

  always #5 clk = ~clk;

  adder_ctrl dut (
    .m1_axi_aclk    (clk),
    .m1_axi_areset  (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_sum        (rsp_sum),
    .rsp_err        (rsp_err),
    .m1_axi_awaddr  (awaddr),
    .m1_axi_awvalid (awvalid),
    .m1_axi_awready (awready),
    .m1_axi_wdata   (wdata),
    .m1_axi_wstrb   (wstrb),
    .m1_axi_wvalid  (wvalid),
    .m1_axi_wready  (wready),
    .m1_axi_bresp   (bresp),
    .m1_axi_bvalid  (bvalid),
    .m1_axi_bready  (bready),
    .m1_axi_araddr  (araddr),
    .m1_axi_arvalid (arvalid),
    .m1_axi_arready (arready),
    .m1_axi_rdata   (rdata),
    .m1_axi_rresp   (rresp),
    .m1_axi_rvalid  (rvalid),
    .m1_axi_rready  (rready)
  );

  // ---------------- adder slave model ----------------
  int          aw_cnt = 0;
  logic        aw_seen = 1'b0, w_seen = 1'b0;
  logic [7:0]  aw_addr_s = '0;
  logic [31:0] w_data_s = '0;
  logic [3:0]  w_strb_s = '0;
  logic [31:0] reg_a = '0, reg_b = '0;
  logic [7:0]  wlog_addr [0:31];
  logic [31:0] wlog_data [0:31];
  logic [3:0]  wlog_strb [0:31];
  int          n_wr = 0;
  int          n_rd = 0;
  logic [7:0]  last_araddr = '0;

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = ar_en;

  always @(posedge clk) begin : slave
    logic        aw_now, w_now;
    logic [7:0]  a_now;
    logic [31:0] d_now;
    logic [3:0]  s_now;
    if (rst) begin
      aw_cnt  <= 0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= 1'b0;
      rdata   <= '0;
    end else begin
      if (!awvalid) aw_cnt <= 0;
      else if (!awready) aw_cnt <= aw_cnt + 1;
      aw_now = aw_seen | (awvalid & awready);
      w_now  = w_seen  | (wvalid & wready);
      a_now  = (awvalid & awready) ? awaddr : aw_addr_s;
      d_now  = (wvalid & wready) ? wdata : w_data_s;
      s_now  = (wvalid & wready) ? wstrb : w_strb_s;
      if (aw_now && w_now && !bvalid) begin
        bvalid  <= 1'b1;
        bresp   <= err_on_b && (a_now == 8'h04);
        wlog_addr[n_wr[4:0]] <= a_now;
        wlog_data[n_wr[4:0]] <= d_now;
        wlog_strb[n_wr[4:0]] <= s_now;
        n_wr    <= n_wr + 1;
        if (a_now == 8'h00) reg_a <= d_now;
        if (a_now == 8'h04) reg_b <= d_now;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        aw_seen   <= aw_now;
        w_seen    <= w_now;
        aw_addr_s <= a_now;
        w_data_s  <= d_now;
        w_strb_s  <= s_now;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid      <= 1'b1;
        rresp       <= 1'b0;
        rdata       <= reg_a + reg_b;
        n_rd        <= n_rd + 1;
        last_araddr <= araddr;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Returns cycles from the command handshake edge to rsp_valid, or -1.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("rsp_arrived", 32'(lat != -1), 32'd1);
  endtask

  task automatic release_rsp();
    @(negedge clk) rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, aw_hi, w_hi, bad, rd0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Zero-wait job: 39 + 40.
    do_cmd(32'd39, 32'd40);
    wait_rsp(lat);
    chk("zw_latency", 32'(lat), 32'd7);
    chk("zw_sum", rsp_sum, 32'd79);
    chk("zw_err", 32'(rsp_err), 32'd0);
    chk("zw_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("zw_n_wr", 32'(n_wr), 32'd2);
    chk("zw_wr0_addr", 32'(wlog_addr[0]), 32'h00);
    chk("zw_wr0_data", wlog_data[0], 32'd39);
    chk("zw_wr1_addr", 32'(wlog_addr[1]), 32'h04);
    chk("zw_wr1_data", wlog_data[1], 32'd40);
    chk("zw_wstrb", 32'(wlog_strb[1]), 32'hF);
    chk("zw_n_rd", 32'(n_rd), 32'd1);
    chk("zw_araddr", 32'(last_araddr), 32'h08);
    release_rsp();

    // awready held off 3 cycles on the operand-A write.
    aw_delay = 3;
    do_cmd(32'd100, 32'd23);
    aw_hi = 0; w_hi = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid && awaddr != 8'h00) bad++;
      if (bready && (awvalid || wvalid)) bad++;
      if (bready) break;
    end
    chk("dly_aw_cycles", 32'(aw_hi), 32'd4);
    chk("dly_w_cycles", 32'(w_hi), 32'd1);
    chk("dly_bready_order", 32'(bad), 32'd0);
    chk("dly_bready_seen", 32'(bready), 32'd1);
    wait_rsp(lat);
    chk("dly_sum", rsp_sum, 32'd123);
    release_rsp();
    aw_delay = 0;

    // Error response on operand B does not abort the read.
    err_on_b = 1'b1;
    rd0 = n_rd;
    do_cmd(32'd5, 32'd6);
    wait_rsp(lat);
    chk("berr_read_issued", 32'(n_rd - rd0), 32'd1);
    chk("berr_araddr", 32'(last_araddr), 32'h08);
    chk("berr_err", 32'(rsp_err), 32'd1);
    chk("berr_sum", rsp_sum, 32'd11);
    release_rsp();
    err_on_b = 1'b0;
    do_cmd(32'd1000, 32'd2000);
    wait_rsp(lat);
    chk("clean_err", 32'(rsp_err), 32'd0);
    chk("clean_sum", rsp_sum, 32'd3000);

    // Back-pressure on the response channel.
    release_rsp();
    do_cmd(32'hFFFF_FFFF, 32'd2);
    wait_rsp(lat);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_sum != 32'd1 || cmd_ready) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_wrap_sum", rsp_sum, 32'd1);
    release_rsp();

    // Reset while the operand-B write is outstanding.
    do_cmd(32'd9, 32'd10);
    bad = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (awvalid && awaddr == 8'h04) begin
        bad = 0;
        break;
      end
    end
    chk("rstwb_reached", 32'(bad), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwb_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rstwb_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstwb_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwb_sum", rsp_sum, 32'd0);
    do_cmd(32'd1, 32'd2);
    wait_rsp(lat);
    chk("post_rst_latency", 32'(lat), 32'd7);
    chk("post_rst_sum", rsp_sum, 32'd3);
    release_rsp();

`ifdef ADDER_CTRL_TIMEOUT_EN
    ar_en = 1'b0;
    do_cmd(32'd4, 32'd4);
    aw_hi = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (arvalid) aw_hi++;
      else if (aw_hi > 0) break;
    end
    chk("to_ar_cycles", 32'(aw_hi), 32'd255);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_sum", rsp_sum, 32'd0);
    release_rsp();
    ar_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/adder_ctrl.md
ADDER_CTRL -- requirements
Module: adder_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand, result and AXI data width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set AXI address width.
REQ-003 Parameter BASE_ADDR, default 0, SHALL set the adder slave base address; offsets 0x00 (A), 0x04 (B), 0x08 (sum).
REQ-004 m1_axi_aclk  in  1  SHALL be the single clock; all logic on rising edge.
REQ-005 m1_axi_areset  in  1  SHALL be synchronous, active-high reset.
REQ-006 cmd_valid  in  1  SHALL flag a valid job request.
REQ-007 cmd_ready  out  1  SHALL flag job acceptance.
REQ-008 cmd_a  in  DATA_WIDTH  SHALL carry operand A.
REQ-009 cmd_b  in  DATA_WIDTH  SHALL carry operand B.
REQ-010 rsp_valid  out  1  SHALL flag a valid result.
REQ-011 rsp_ready  in  1  SHALL flag result consumption.
REQ-012 rsp_sum  out  DATA_WIDTH  SHALL carry the sum read from the slave.
REQ-013 rsp_err  out  1  SHALL flag any error response or timeout during the job.
REQ-014 m1_axi_awaddr  out  ADDR_WIDTH  SHALL carry write address.
REQ-015 m1_axi_awvalid  out  1  SHALL flag valid write address.
REQ-016 m1_axi_awready  in  1  SHALL flag slave address acceptance.
REQ-017 m1_axi_wdata  out  DATA_WIDTH  SHALL carry write data.
REQ-018 m1_axi_wstrb  out  DATA_WIDTH/8  SHALL carry byte strobes.
REQ-019 m1_axi_wvalid  out  1  SHALL flag valid write data.
REQ-020 m1_axi_wready  in  1  SHALL flag slave data acceptance.
REQ-021 m1_axi_bresp  in  1  SHALL be the write response; 1 = error.
REQ-022 m1_axi_bvalid  in  1  SHALL flag valid write response.
REQ-023 m1_axi_bready  out  1  SHALL flag write response acceptance.
REQ-024 m1_axi_araddr  out  ADDR_WIDTH  SHALL carry read address.
REQ-025 m1_axi_arvalid  out  1  SHALL flag valid read address.
REQ-026 m1_axi_arready  in  1  SHALL flag slave read-address acceptance.
REQ-027 m1_axi_rdata  in  DATA_WIDTH  SHALL carry read data.
REQ-028 m1_axi_rresp  in  1  SHALL be the read response; 1 = error.
REQ-029 m1_axi_rvalid  in  1  SHALL flag valid read data.
REQ-030 m1_axi_rready  out  1  SHALL flag read data acceptance.

Function
REQ-031 FSM states IDLE, WR_A, WR_B, RD, RSP; cmd_ready SHALL be 1 only in IDLE; cmd handshake captures cmd_a/cmd_b, clears error flag, moves to WR_A.
REQ-032 WR_A/WR_B SHALL assert awvalid and wvalid together with awaddr=BASE_ADDR+0x00/0x04, wdata=A/B, wstrb all ones; each valid drops on its own handshake, independently.
REQ-033 bready SHALL assert only once both AW and W are accepted; bvalid&bready SHALL OR bresp into error flag and advance WR_A->WR_B->RD.
REQ-034 RD SHALL hold arvalid with araddr=BASE_ADDR+0x08 until arready, then assert rready; rvalid&rready SHALL capture rdata into rsp_sum, OR rresp into error flag, move to RSP.
REQ-035 RSP SHALL hold rsp_valid, rsp_sum, rsp_err stable until rsp_ready, then return to IDLE; cmd_ready and rsp_valid SHALL never both be 1.
REQ-036 Error responses SHALL NOT abort the sequence; all three transfers always complete.
REQ-037 All AXI valids, addresses and data SHALL be registered, stable until handshake, with no combinational ready-to-valid path.
REQ-038 With a zero-wait slave (ready always 1, responses registered one cycle later), rsp_valid SHALL rise exactly 7 cycles after the cmd handshake edge.

Reset
REQ-039 m1_axi_areset SHALL, at any state, force IDLE on the next edge: all AXI valids, bready, rready, rsp_valid, rsp_err = 0, rsp_sum = 0, cmd_ready = 1, in-flight job discarded.

Configuration
REQ-040 With ADDER_CTRL_TIMEOUT_EN defined, a wait counter SHALL abort any handshake wait exceeding ADDER_CTRL_TIMEOUT cycles (drop all valids, rsp_sum=0, rsp_err=1, go RSP); without it, no counter exists and waits are unbounded.

Structure
REQ-041 Package adder_ctrl_pkg SHALL hold the FSM state enum, register offsets 0x00/0x04/0x08 and ADDER_CTRL_TIMEOUT (255).
REQ-042 Sub-module axil_wr_xfer SHALL implement one AW/W/B write transfer and be reused for both operand writes.

Verification
REQ-043 A=39, B=40, zero-wait slave returning 79 -> writes (0x00,39), (0x04,40), read 0x08, rsp_sum=79, rsp_err=0, rsp_valid 7 cycles after cmd handshake.
REQ-044 awready delayed 3 cycles, wready immediate -> wvalid high 1 cycle, awvalid/awaddr=0x00 stable 4 cycles, bready only after both accepted, rsp_sum correct.
REQ-045 bresp=1 on operand-B write -> read of 0x08 still issued, rsp_err=1; next job with clean responses -> rsp_err=0.
REQ-046 rsp_ready low 5 cycles -> rsp_valid/rsp_sum stable, cmd_ready=0; reset during WR_B -> next cycle all valids 0, cmd_ready=1.
REQ-047 ADDER_CTRL_TIMEOUT_EN defined, arready never asserted -> arvalid drops after 255 cycles, rsp_valid=1, rsp_err=1, rsp_sum=0.
